// File: rtl/flag_pipe_unit.sv
// flag_pipe_unit: registered FANIN-ary zero-detect tree carrying N/C/V/set_flags, committing NZCV flags.
// Optional FLAG_BYPASS_EN forwards a same-cycle commit straight onto flags.
module flag_pipe_unit #(
  parameter int WIDTH = 64,
  parameter int FANIN = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic             set_flags,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             zero_out,
  output logic             neg_out,
  output logic [3:0]       flags
);

  function automatic int calc_levels(input int w, input int f);
    int     l;
    longint span;
    l    = 1;
    span = longint'(f);
    while (span < longint'(w)) begin
      span = span * longint'(f);
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = calc_levels(WIDTH, FANIN);
  localparam int PAD_W  = FANIN ** LEVELS;

  logic [PAD_W-1:0]  padded;
  logic [LEVELS-1:0] vld;
  logic [LEVELS-1:0] neg_p;
  logic [LEVELS-1:0] car_p;
  logic [LEVELS-1:0] ovf_p;
  logic [LEVELS-1:0] sf_p;
  logic [3:0]        flag_reg;
  logic [3:0]        flag_next;
  logic              commit;

  // Zero padding NORs to 1 and so acts as the all-ones tie-off in the AND levels.
  assign padded = PAD_W'(result);

  for (genvar lv = 0; lv < LEVELS; lv++) begin : lvl
    localparam int N = FANIN ** (LEVELS - 1 - lv);
    logic [N-1:0] node;
    logic [N-1:0] nxt;

    if (lv == 0) begin : g_nor
      always_comb begin
        nxt = '0;
        for (int unsigned g = 0; g < N; g++) begin
          nxt[g] = ~|padded[g*FANIN +: FANIN];
        end
      end
    end else begin : g_and
      logic [N*FANIN-1:0] prev;
      assign prev = lvl[lv-1].node;
      always_comb begin
        nxt = '0;
        for (int unsigned g = 0; g < N; g++) begin
          nxt[g] = &prev[g*FANIN +: FANIN];
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        node <= '0;
      end else if (!stall) begin
        node <= nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld   <= '0;
      neg_p <= '0;
      car_p <= '0;
      ovf_p <= '0;
      sf_p  <= '0;
    end else begin
      if (flush) begin
        vld <= '0;
      end else if (!stall) begin
        vld[0] <= in_valid;
        for (int unsigned i = 1; i < LEVELS; i++) begin
          vld[i] <= vld[i-1];
        end
      end
      if (!stall) begin
        neg_p[0] <= result[WIDTH-1];
        car_p[0] <= carry_in;
        ovf_p[0] <= overflow_in;
        sf_p[0]  <= set_flags;
        for (int unsigned i = 1; i < LEVELS; i++) begin
          neg_p[i] <= neg_p[i-1];
          car_p[i] <= car_p[i-1];
          ovf_p[i] <= ovf_p[i-1];
          sf_p[i]  <= sf_p[i-1];
        end
      end
    end
  end

  assign out_valid = vld[LEVELS-1];
  assign zero_out  = lvl[LEVELS-1].node[0];
  assign neg_out   = neg_p[LEVELS-1];

  assign commit    = out_valid & sf_p[LEVELS-1] & ~stall & ~flush;
  assign flag_next = {neg_out, zero_out, car_p[LEVELS-1], ovf_p[LEVELS-1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_reg <= '0;
    end else if (commit) begin
      flag_reg <= flag_next;
    end
  end

`ifdef FLAG_BYPASS_EN
  always_comb flags = commit ? flag_next : flag_reg;
`else
  always_comb flags = flag_reg;
`endif

endmodule

// File: tb/tb_flag_pipe_unit.sv
// Bench for flag_pipe_unit: scoreboard monitor on the 64/4 instance plus directed scenario tasks.
module tb_flag_pipe_unit;

`ifdef FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, carry_in, overflow_in, set_flags, stall, flush;
  logic [63:0] result;
  logic        out_valid, zero_out, neg_out;
  logic [3:0]  flags;

  logic        s_in_valid, s_carry, s_ovf, s_sf, s_stall, s_flush;
  logic [4:0]  s_result;
  logic        s_out_valid, s_zero, s_neg;
  logic [3:0]  s_flags;

  int total = 0;
  int bad   = 0;

  typedef struct packed {logic z; logic n; logic c; logic v; logic sf;} ent_t;
  ent_t       q[$];
  logic [3:0] exp_flags = '0;
  logic [3:0] pend_val  = '0;
  bit         pend      = 1'b0;

  always #5 clk = ~clk;

  flag_pipe_unit #(.WIDTH(64), .FANIN(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .result(result),
    .carry_in(carry_in), .overflow_in(overflow_in), .set_flags(set_flags),
    .stall(stall), .flush(flush), .out_valid(out_valid), .zero_out(zero_out),
    .neg_out(neg_out), .flags(flags)
  );

  flag_pipe_unit #(.WIDTH(5), .FANIN(4)) u_small (
    .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .result(s_result),
    .carry_in(s_carry), .overflow_in(s_ovf), .set_flags(s_sf),
    .stall(s_stall), .flush(s_flush), .out_valid(s_out_valid), .zero_out(s_zero),
    .neg_out(s_neg), .flags(s_flags)
  );

  // Entries enter at the edge they are accepted; a flush kills everything still in flight.
  always @(posedge clk) begin
    if (reset_n) begin
      if (flush) q.delete();
      else if (in_valid && !stall)
        q.push_back('{z: (result == 64'h0), n: result[63], c: carry_in, v: overflow_in, sf: set_flags});
    end
  end

  always @(negedge reset_n) begin
    q.delete();
    exp_flags = '0;
    pend      = 1'b0;
  end

  always @(negedge clk) begin
    ent_t       e;
    bit         commit_now;
    logic [3:0] exp_now;
    if (reset_n) begin
      if (pend) begin
        exp_flags = pend_val;
        pend      = 1'b0;
      end
      commit_now = 1'b0;
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: out_valid=1 with no entry expected at %0t", $time);
        end else begin
          e = q[0];
          if ({zero_out, neg_out} !== {e.z, e.n}) begin
            bad++;
            $display("FAIL sb_zn: got z=%b n=%b expected z=%b n=%b at %0t", zero_out, neg_out, e.z, e.n, $time);
          end
          if (!stall) begin
            void'(q.pop_front());
            if (!flush && e.sf) begin
              commit_now = 1'b1;
              pend       = 1'b1;
              pend_val   = {e.n, e.z, e.c, e.v};
            end
          end
        end
      end
      exp_now = (BYPASS && commit_now) ? pend_val : exp_flags;
      total++;
      if (flags !== exp_now) begin
        bad++;
        $display("FAIL sb_flags: got %b expected %b at %0t", flags, exp_now, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] r, input logic c, input logic v, input logic sf);
    result = r; carry_in = c; overflow_in = v; set_flags = sf; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    total++;
    if ({out_valid, zero_out, neg_out, flags, s_out_valid, s_flags} !== 11'b0) begin
      bad++;
      $display("FAIL reset_state: got ov=%b z=%b n=%b flags=%b s_ov=%b s_flags=%b expected all 0",
               out_valid, zero_out, neg_out, flags, s_out_valid, s_flags);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    send(64'h0, 1'b1, 1'b0, 1'b1);
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early: out_valid=%b expected 0", out_valid); end
    step();
    total++;
    if ({out_valid, zero_out} !== 2'b11) begin
      bad++; $display("FAIL basic_exit: ov=%b z=%b expected 1 1", out_valid, zero_out);
    end
    total++;
    if (flags !== (BYPASS ? 4'b0110 : 4'b0000)) begin
      bad++; $display("FAIL basic_flags_exit: got %b expected %b", flags, BYPASS ? 4'b0110 : 4'b0000);
    end
    step();
    total++;
    if (flags !== 4'b0110) begin bad++; $display("FAIL basic_flags: got %b expected 0110", flags); end
  endtask

  task automatic test_negative();
    send(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
    step(); step(); step();
    total++;
    if (flags !== 4'b1001) begin bad++; $display("FAIL neg_flags: got %b expected 1001", flags); end
    send(64'h1, 1'b1, 1'b1, 1'b0);
    step(); step(); step();
    total++;
    if (flags !== 4'b1001) begin bad++; $display("FAIL nosf_flags: got %b expected 1001", flags); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq;
    int n = 0, first = -1, last = -1;
    seq = '0;
    result = 64'h0;  in_valid = 1'b1; set_flags = 1'b0; step();
    result = 64'hF;  step();
    result = 64'h0;  step();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (n < 3) seq[n] = zero_out;
        if (first < 0) first = i;
        last = i;
        n++;
      end
    end
    total++;
    if (n !== 3 || seq !== 3'b101 || last - first !== 2) begin
      bad++;
      $display("FAIL b2b: got count=%0d seq=%b span=%0d expected count=3 seq=101 span=2", n, seq, last - first);
    end
    step();
  endtask

  task automatic test_stall();
    send(64'h0, 1'b1, 1'b1, 1'b1);
    step();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0 || flags !== 4'b1001) begin
        bad++; $display("FAIL stall_hold%0d: ov=%b flags=%b expected 0 1001", i, out_valid, flags);
      end
    end
    stall = 1'b0;
    step();
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, zero_out, neg_out, flags} !== 7'b1101001) begin
        bad++;
        $display("FAIL stall_exit%0d: ov=%b z=%b n=%b flags=%b expected 1 1 0 1001", i, out_valid, zero_out, neg_out, flags);
      end
      if (i < 2) step();
    end
    stall = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || flags !== 4'b0111) begin
      bad++; $display("FAIL stall_commit: ov=%b flags=%b expected 0 0111", out_valid, flags);
    end
  endtask

  task automatic test_flush();
    result = 64'h0; carry_in = 1'b0; overflow_in = 1'b0; set_flags = 1'b1; in_valid = 1'b1;
    step();
    result = 64'h1;
    step();
    flush = 1'b1; result = 64'h0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0 || flags !== 4'b0111) begin
        bad++; $display("FAIL flush_kill%0d: ov=%b flags=%b expected 0 0111", i, out_valid, flags);
      end
    end
    send(64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1);
    step(); step();
    flush = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b1 || flags !== 4'b0111) begin
      bad++; $display("FAIL flush_exit: ov=%b flags=%b expected 1 0111", out_valid, flags);
    end
    step();
    flush = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || flags !== 4'b0111) begin
      bad++; $display("FAIL flush_nocommit: ov=%b flags=%b expected 0 0111", out_valid, flags);
    end
    send(64'h0, 1'b0, 1'b0, 1'b1);
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0 || flags !== 4'b0111) begin
        bad++; $display("FAIL flush_over_stall%0d: ov=%b flags=%b expected 0 0111", i, out_valid, flags);
      end
    end
  endtask

  task automatic test_async_reset();
    send(64'h0, 1'b1, 1'b0, 1'b1);
    result = 64'h5; in_valid = 1'b1; set_flags = 1'b1;
    step();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({out_valid, zero_out, neg_out, flags} !== 7'b0) begin
      bad++; $display("FAIL async_reset: ov=%b z=%b n=%b flags=%b expected all 0", out_valid, zero_out, neg_out, flags);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0 || flags !== 4'b0000) begin
        bad++; $display("FAIL post_reset%0d: ov=%b flags=%b expected 0 0000", i, out_valid, flags);
      end
    end
  endtask

  task automatic test_small_width();
    s_result = 5'b10000; s_carry = 1'b0; s_ovf = 1'b0; s_sf = 1'b1; s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    step();
    total++;
    if ({s_out_valid, s_zero, s_neg} !== 3'b101) begin
      bad++; $display("FAIL small_msb: ov=%b z=%b n=%b expected 1 0 1", s_out_valid, s_zero, s_neg);
    end
    total++;
    if (s_flags !== (BYPASS ? 4'b1000 : 4'b0000)) begin
      bad++; $display("FAIL small_msb_flags_exit: got %b expected %b", s_flags, BYPASS ? 4'b1000 : 4'b0000);
    end
    s_result = 5'b00000; s_carry = 1'b1; s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    total++;
    if (s_flags !== 4'b1000) begin bad++; $display("FAIL small_msb_flags: got %b expected 1000", s_flags); end
    step();
    total++;
    if ({s_out_valid, s_zero, s_neg} !== 3'b110) begin
      bad++; $display("FAIL small_zero: ov=%b z=%b n=%b expected 1 1 0", s_out_valid, s_zero, s_neg);
    end
    total++;
    if (s_flags !== (BYPASS ? 4'b0110 : 4'b1000)) begin
      bad++; $display("FAIL small_zero_flags_exit: got %b expected %b", s_flags, BYPASS ? 4'b0110 : 4'b1000);
    end
    step();
    total++;
    if (s_flags !== 4'b0110 || s_out_valid !== 1'b0) begin
      bad++; $display("FAIL small_zero_flags: flags=%b ov=%b expected 0110 0", s_flags, s_out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; result = '0; carry_in = 1'b0; overflow_in = 1'b0;
    set_flags = 1'b0; stall = 1'b0; flush = 1'b0;
    s_in_valid = 1'b0; s_result = '0; s_carry = 1'b0; s_ovf = 1'b0;
    s_sf = 1'b0; s_stall = 1'b0; s_flush = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_small_width();
    step(); step();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL sb_drain: %0d entries never exited, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_pipe_unit.md
Name: flag_pipe_unit

Overview:
- Parametrised, pipelined successor to the single-cycle zero detector. Used by the 5-stage pipeline between EX and the architectural condition-flag register.
- Reduces a WIDTH-bit ALU result through a registered FANIN-ary NOR/AND tree to produce Z. Carries N/C/V alongside in the pipeline.
- Commits NZCV into an architectural flag register when the operation has set_flags.
- Supports pipeline stall and flush.

Parameters:
- WIDTH, 64, result width in bits; any value ≥1.
- FANIN, 4, inputs per reduction gate per level; ≥2.
- LEVELS, derived (localparam), ceil(log_FANIN(WIDTH)), minimum 1; equals the pipeline latency in cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  result/flag inputs valid this cycle.
- result  in  WIDTH  ALU result.
- carry_in  in  1  ALU carry out.
- overflow_in  in  1  ALU signed overflow.
- set_flags  in  1  operation updates the architectural flags.
- stall  in  1  hold all pipeline registers.
- flush  in  1  kill all in-flight entries, including the current input.
- out_valid  out  1  reduced entry leaving the last level this cycle.
- zero_out  out  1  Z of the exiting entry.
- neg_out  out  1  N of the exiting entry (result[WIDTH-1]).
- flags  out  4  architectural {N,Z,C,V}.

Behaviour:
- Reset: every level's valid bit = 0, out_valid = 0, zero_out = 0, neg_out = 0, flags = 4'b0000.
  - Reset is asynchronous and takes effect mid-operation; all in-flight entries are lost.
- Level 0:
  - Pad result with zeros to FANIN^LEVELS bits (padding never affects Z).
  - Each group of FANIN bits is NORed; the outputs are registered.
- Levels 1..LEVELS-1: each group of FANIN registered bits is ANDed and registered; unused tail inputs are tied to 1.
- Sideband registers travel in lockstep with the tree: valid, N, C, V, set_flags.
- Latency:
  - Input accepted at edge k appears on out_valid/zero_out/neg_out after edge k+LEVELS-1, i.e. registered out of the last level.
  - WIDTH=64, FANIN=4 gives LEVELS=3. WIDTH≤FANIN gives LEVELS=1.
- Throughput: one entry per cycle when stall=0.
- stall=1: all pipeline registers and flags hold; in_valid is ignored; outputs remain stable.
- flush=1:
  - At the next edge all valid bits clear; in_valid in the same cycle is dropped.
  - flags is not updated by an entry exiting in the flush cycle.
  - flush has priority over stall.
- Commit:
  - When out_valid=1, the exiting set_flags=1, stall=0 and flush=0, flags <= {neg_out, zero_out, C, V} at that edge.
  - Otherwise flags holds.
- Data in invalid slots is don't-care; only valid bits are reset-cleared.
- zero_out/neg_out are only meaningful while out_valid=1.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: flags is combinational. When a commit is occurring this cycle, flags shows the value being written; otherwise it shows the register. This lets a dependent branch in the same cycle see fresh flags.
- Undefined: flags is purely the registered value, updating one edge after commit.

Test Plan:
- Default params; reset_n low then high; result=64'h0, in_valid=1, set_flags=1, C=1, V=0 for one cycle -> out_valid=1 and zero_out=1 three cycles later; flags=4'b0110 after that edge.
- result=64'h8000_0000_0000_0000, set_flags=1, C=0, V=1 -> zero_out=0, neg_out=1; flags=4'b1001. Then result=64'h0000_0000_0000_0001 with set_flags=0 -> zero_out=0 and flags unchanged at 4'b1001.
- Back-to-back results 0, 64'hF, 0 on consecutive cycles -> zero_out sequence 1,0,1 on three consecutive out_valid cycles.
- Inject result 0 (set_flags=1), then assert stall for 5 cycles mid-flight -> outputs frozen during the stall; the entry exits LEVELS cycles after injection plus 5.
- Two entries in flight, flush with in_valid=1 the same cycle -> no out_valid for the next LEVELS cycles; flags unchanged. Also: reset_n asserted mid-flight -> out_valid=0 and flags=0 immediately, without a clock edge.
- WIDTH=5, FANIN=4 (LEVELS=2): result=5'b10000 -> zero_out=0; result=5'b00000 -> zero_out=1. With FLAG_BYPASS_EN defined, flags equals the committed value in the same cycle out_valid=1.
